data_mem_resp: RTL and testbench
================================

// Module: data_mem_resp
// PURPOSE
//  Data-memory responder on the memory side of the load/store unit. It accepts one
//  read_en/write_en request per cycle, writes SB/SW into a byte-addressed array, and
//  returns LB/LW data with the destination tag and PC after a fixed pipelined latency.
//  Load responses feed the completion/writeback path. Store acks feed store retirement.
// PARAMETERS
//  DEPTH     1024  bytes of storage. Power of two. Address is taken modulo DEPTH.
//  LAT       2     load latency in cycles from request edge to load_valid_out. 1..8.
//  OP_LB     4'd7  opcode: load byte, sign-extended.
//  OP_LW     4'd8  opcode: load word.
//  OP_SB     4'd9  opcode: store byte.
//  OP_SW     4'd10 opcode: store word.
// PORTS
//  clk             in   1   clock; all state changes on the rising edge
//  rst             in   1   asynchronous, active-high reset
//  read_en_in      in   1   load request valid this cycle
//  write_en_in     in   1   store request valid this cycle
//  op_in           in   4   OP_LB/OP_LW/OP_SB/OP_SW
//  mem_addr_in     in   32  byte address
//  store_data_in   in   32  SW uses [31:0]; SB uses [7:0]
//  reg_in          in   6   destination physical register of a load
//  inst_pc_in      in   32  PC of the requesting instruction
//  load_valid_out  out  1   1-cycle pulse: load response valid
//  load_data_out   out  32  load result; LB is sign-extended from byte
//  reg_out         out  6   destination tag for load_data_out
//  inst_pc_out     out  32  PC of the completing load
//  store_done_out  out  1   1-cycle pulse, cycle after a store is accepted
//  store_pc_out    out  32  PC of the acknowledged store
//  err_out         out  1   1-cycle pulse: misaligned LW/SW, bad op, or rd+wr conflict
// BEHAVIOUR
//  Reset:
//   - On rst, all outputs go to 0 immediately.
//   - The load pipeline is flushed, and queued responses are discarded.
//   - Every memory byte is cleared to 0.
//   - Reset mid-operation drops all in-flight loads; none are emitted after release.
//  Acceptance:
//   - A request is sampled at a rising edge when read_en_in or write_en_in is 1.
//   - No backpressure: one request per cycle is always accepted.
//  Store:
//   - A valid store writes the array at the sampling edge.
//   - SW writes 4 bytes little-endian at addr..addr+3. SB writes 1 byte.
//   - store_done_out and store_pc_out are registered at that same edge, so they are
//     visible the following cycle.
//  Load:
//   - A load reads the array at its sampling edge.
//   - It sees all stores sampled at strictly earlier edges. A store in the same cycle
//     is impossible; see Conflict.
//   - The result moves through an LAT-deep shift register of {valid, data, tag, pc}.
//   - load_valid_out rises LAT cycles after the request edge.
//     LAT=1 means load_valid_out is registered at the request edge.
//   - Back-to-back loads produce back-to-back responses, in order.
//  Alignment:
//   - LW/SW require addr[1:0]==0. If not: no write, no response; err_out pulses next cycle.
//   - LB/SB accept any address.
//  Wrap-around: the effective byte index is addr mod DEPTH; high bits are ignored.
//  Bad op: read_en_in with op_in not LB/LW, or write_en_in with op_in not SB/SW:
//   - The request is ignored, and err_out pulses next cycle.
//  Conflict: read_en_in and write_en_in both 1:
//   - The store is performed, and the load is dropped.
//   - err_out pulses. store_done_out pulses as normal.
//  Outputs hold their last value when the valid strobe is 0, except valid/done/err,
//   which return to 0.
// TESTING
//  1. rst pulse mid-cycle with no clock -> all outputs 0 at once; LW addr 0 -> data 0.
//  2. SW addr 0x10 data 0xDEADBEEF; next cycle LW 0x10 tag 5
//       -> LAT cycles later load_valid_out=1, data 0xDEADBEEF, reg_out=5.
//  3. LB 0x13 after (2) -> data 0xFFFFFFDE.
//     SB 0x11 data 0x7A, then LW 0x10 -> data 0xDEAD7AEF.
//  4. 4 consecutive LWs to 0x0,0x4,0x8,0xC -> 4 consecutive pulses, in order, correct
//     tags and PCs.
//  5. LW at 0x102 -> no load_valid_out, err_out=1.
//     SW to DEPTH+0x20 -> reading 0x20 returns the stored word.
//  6. LW issued, rst asserted 1 cycle later -> no load_valid_out after reset release.
//     rd+wr together -> store done, err_out=1, no load response.

Source files
------------

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - byte-addressed data memory responder with a fixed-latency load pipeline
module data_mem_resp #(
    parameter int         DEPTH = 1024,
    parameter int         LAT   = 2,
    parameter logic [3:0] OP_LB = 4'd7,
    parameter logic [3:0] OP_LW = 4'd8,
    parameter logic [3:0] OP_SB = 4'd9,
    parameter logic [3:0] OP_SW = 4'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en_in,
    input  logic        write_en_in,
    input  logic [3:0]  op_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] store_data_in,
    input  logic [5:0]  reg_in,
    input  logic [31:0] inst_pc_in,
    output logic        load_valid_out,
    output logic [31:0] load_data_out,
    output logic [5:0]  reg_out,
    output logic [31:0] inst_pc_out,
    output logic        store_done_out,
    output logic [31:0] store_pc_out,
    output logic        err_out
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] idx0, idx1, idx2, idx3;
    logic          aligned, is_lb, is_lw, is_sb, is_sw;
    logic          rd_ok, wr_ok, err_next;
    logic [31:0]   rd_data;
    logic          unused_addr_hi;

    logic          pv [LAT];
    logic [31:0]   pd [LAT];
    logic [5:0]    pt [LAT];
    logic [31:0]   pp [LAT];

    // High address bits are deliberately ignored: the array wraps modulo DEPTH.
    assign unused_addr_hi = ^mem_addr_in[31:AW];

    assign idx0    = mem_addr_in[AW-1:0];
    assign idx1    = idx0 + AW'(1);
    assign idx2    = idx0 + AW'(2);
    assign idx3    = idx0 + AW'(3);
    assign aligned = (mem_addr_in[1:0] == 2'b00);
    assign is_lb   = (op_in == OP_LB);
    assign is_lw   = (op_in == OP_LW);
    assign is_sb   = (op_in == OP_SB);
    assign is_sw   = (op_in == OP_SW);

    // A simultaneous read and write keeps the store and drops the load.
    assign rd_ok = read_en_in && !write_en_in && (is_lb || (is_lw && aligned));
    assign wr_ok = write_en_in && (is_sb || (is_sw && aligned));

    assign err_next = (read_en_in && write_en_in)
                   || (read_en_in && !(is_lb || is_lw))
                   || (write_en_in && !(is_sb || is_sw))
                   || (read_en_in && is_lw && !aligned)
                   || (write_en_in && is_sw && !aligned);

    assign rd_data = is_lb ? {{24{mem[idx0][7]}}, mem[idx0]}
                           : {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};

    assign load_valid_out = pv[LAT-1];
    assign load_data_out  = pd[LAT-1];
    assign reg_out        = pt[LAT-1];
    assign inst_pc_out    = pp[LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
                pt[i] <= '0;
                pp[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            store_done_out <= 1'b0;
            store_pc_out   <= '0;
            err_out        <= 1'b0;
        end else begin
            pv[0] <= rd_ok;
            if (rd_ok) begin
                pd[0] <= rd_data;
                pt[0] <= reg_in;
                pp[0] <= inst_pc_in;
            end
            // Payload only advances behind a valid so the outputs hold across bubbles.
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    pd[i] <= pd[i-1];
                    pt[i] <= pt[i-1];
                    pp[i] <= pp[i-1];
                end
            end
            store_done_out <= wr_ok;
            if (wr_ok) begin
                store_pc_out <= inst_pc_in;
                mem[idx0]    <= store_data_in[7:0];
                if (is_sw) begin
                    mem[idx1] <= store_data_in[15:8];
                    mem[idx2] <= store_data_in[23:16];
                    mem[idx3] <= store_data_in[31:24];
                end
            end
            err_out <= err_next;
        end
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - directed self-checking bench for data_mem_resp
module tb_data_mem_resp;
    localparam int         DEPTH = 1024;
    localparam int         LAT   = 2;
    localparam logic [3:0] OP_LB = 4'd7;
    localparam logic [3:0] OP_LW = 4'd8;
    localparam logic [3:0] OP_SB = 4'd9;
    localparam logic [3:0] OP_SW = 4'd10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_en_in = 1'b0;
    logic        write_en_in = 1'b0;
    logic [3:0]  op_in = '0;
    logic [31:0] mem_addr_in = '0;
    logic [31:0] store_data_in = '0;
    logic [5:0]  reg_in = '0;
    logic [31:0] inst_pc_in = '0;
    logic        load_valid_out;
    logic [31:0] load_data_out;
    logic [5:0]  reg_out;
    logic [31:0] inst_pc_out;
    logic        store_done_out;
    logic [31:0] store_pc_out;
    logic        err_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] b2b_data [4];

    data_mem_resp #(
        .DEPTH(DEPTH), .LAT(LAT),
        .OP_LB(OP_LB), .OP_LW(OP_LW), .OP_SB(OP_SB), .OP_SW(OP_SW)
    ) dut (
        .clk(clk), .rst(rst),
        .read_en_in(read_en_in), .write_en_in(write_en_in), .op_in(op_in),
        .mem_addr_in(mem_addr_in), .store_data_in(store_data_in),
        .reg_in(reg_in), .inst_pc_in(inst_pc_in),
        .load_valid_out(load_valid_out), .load_data_out(load_data_out),
        .reg_out(reg_out), .inst_pc_out(inst_pc_out),
        .store_done_out(store_done_out), .store_pc_out(store_pc_out),
        .err_out(err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [3:0] op,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [5:0] tag, input logic [31:0] pc);
        read_en_in    = rd;
        write_en_in   = wr;
        op_in         = op;
        mem_addr_in   = addr;
        store_data_in = data;
        reg_in        = tag;
        inst_pc_in    = pc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 6'd0, 32'd0);
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [3:0] op,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [5:0] tag, input logic [31:0] pc);
        drive(rd, wr, op, addr, data, tag, pc);
        step();
        idle();
    endtask

    task automatic store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] pc);
        issue(1'b0, 1'b1, op, addr, data, 6'd0, pc);
        chk({tag, "_done"}, 32'(store_done_out), 32'd1);
        chk({tag, "_pc"}, store_pc_out, pc);
    endtask

    task automatic load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [5:0] rtag, input logic [31:0] pc, input logic [31:0] exp);
        issue(1'b1, 1'b0, op, addr, 32'd0, rtag, pc);
        repeat (LAT - 1) step();
        chk({tag, "_valid"}, 32'(load_valid_out), 32'd1);
        chk({tag, "_data"}, load_data_out, exp);
        chk({tag, "_reg"}, 32'(reg_out), 32'(rtag));
        chk({tag, "_pc"}, inst_pc_out, pc);
        step();
        chk({tag, "_valid_drop"}, 32'(load_valid_out), 32'd0);
        chk({tag, "_data_hold"}, load_data_out, exp);
    endtask

    task automatic no_resp(input string tag);
        for (int k = 0; k < LAT + 1; k++) begin
            chk(tag, 32'(load_valid_out), 32'd0);
            step();
        end
    endtask

    initial begin
        b2b_data[0] = 32'h01020304;
        b2b_data[1] = 32'h05060708;
        b2b_data[2] = 32'h090A0B0C;
        b2b_data[3] = 32'h0D0E0F10;

        // reset state
        step();
        step();
        chk("rst_valid", 32'(load_valid_out), 32'd0);
        chk("rst_data", load_data_out, 32'd0);
        chk("rst_done", 32'(store_done_out), 32'd0);
        chk("rst_err", 32'(err_out), 32'd0);
        rst = 1'b0;
        step();

        // asynchronous reset between edges clears outputs and memory
        store("pre_sw", OP_SW, 32'h40, 32'h11223344, 32'h100);
        rst = 1'b1;
        #2;
        chk("async_done", 32'(store_done_out), 32'd0);
        chk("async_pc", store_pc_out, 32'd0);
        #1 rst = 1'b0;
        step();
        load("lw_cleared", OP_LW, 32'h40, 6'd1, 32'h104, 32'd0);
        load("lw0_cleared", OP_LW, 32'h0, 6'd2, 32'h108, 32'd0);

        // basic store / load
        store("sw10", OP_SW, 32'h10, 32'hDEADBEEF, 32'h200);
        load("lw10", OP_LW, 32'h10, 6'd5, 32'h204, 32'hDEADBEEF);
        load("lb13", OP_LB, 32'h13, 6'd6, 32'h208, 32'hFFFFFFDE);
        store("sb11", OP_SB, 32'h11, 32'h0000007A, 32'h20C);
        load("lw10_sb", OP_LW, 32'h10, 6'd7, 32'h210, 32'hDEAD7AEF);
        load("lb11_pos", OP_LB, 32'h11, 6'd8, 32'h214, 32'h0000007A);

        // back-to-back loads
        for (int i = 0; i < 4; i++) begin
            store("b2b_sw", OP_SW, 32'(i * 4), b2b_data[i], 32'h300 + 32'(i));
        end
        for (int i = 0; i < 4 + LAT; i++) begin
            if (i < 4) drive(1'b1, 1'b0, OP_LW, 32'(i * 4), 32'd0, 6'(10 + i), 32'h400 + 32'(i * 4));
            else idle();
            step();
            if (i - (LAT - 1) >= 0 && i - (LAT - 1) < 4) begin
                chk("b2b_valid", 32'(load_valid_out), 32'd1);
                chk("b2b_data", load_data_out, b2b_data[i - (LAT - 1)]);
                chk("b2b_reg", 32'(reg_out), 32'(10 + i - (LAT - 1)));
                chk("b2b_pc", inst_pc_out, 32'h400 + 32'((i - (LAT - 1)) * 4));
            end else begin
                chk("b2b_gap", 32'(load_valid_out), 32'd0);
            end
        end
        idle();

        // misaligned, bad op, wrap-around
        issue(1'b1, 1'b0, OP_LW, 32'h102, 32'd0, 6'd3, 32'h500);
        chk("mis_lw_err", 32'(err_out), 32'd1);
        no_resp("mis_lw_noresp");
        chk("err_pulse_end", 32'(err_out), 32'd0);
        store("wrap_sw", OP_SW, DEPTH + 32'h20, 32'hCAFEF00D, 32'h504);
        chk("wrap_sw_err", 32'(err_out), 32'd0);
        load("wrap_lw", OP_LW, 32'h20, 6'd9, 32'h508, 32'hCAFEF00D);
        issue(1'b0, 1'b1, OP_SW, 32'h22, 32'h12345678, 6'd0, 32'h50C);
        chk("mis_sw_err", 32'(err_out), 32'd1);
        chk("mis_sw_done", 32'(store_done_out), 32'd0);
        load("mis_sw_nowrite", OP_LW, 32'h20, 6'd9, 32'h510, 32'hCAFEF00D);
        issue(1'b1, 1'b0, OP_SB, 32'h20, 32'd0, 6'd4, 32'h514);
        chk("badop_err", 32'(err_out), 32'd1);
        no_resp("badop_noresp");

        // read + write conflict
        issue(1'b1, 1'b1, OP_SW, 32'h30, 32'h55AA55AA, 6'd12, 32'h600);
        chk("conf_done", 32'(store_done_out), 32'd1);
        chk("conf_err", 32'(err_out), 32'd1);
        no_resp("conf_noresp");
        load("conf_stored", OP_LW, 32'h30, 6'd13, 32'h604, 32'h55AA55AA);

        // reset drops an in-flight load
        issue(1'b1, 1'b0, OP_LW, 32'h30, 32'd0, 6'd14, 32'h700);
        rst = 1'b1;
        #1;
        chk("flush_valid", 32'(load_valid_out), 32'd0);
        step();
        step();
        rst = 1'b0;
        no_resp("flush_noresp");
        load("flush_mem", OP_LW, 32'h30, 6'd15, 32'h704, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
